// File: rtl/muldivrem_share_arb.sv
// Round-robin sharing of one iterative mul/div/rem unit between two issue streams.
// Optional perf counters are compiled in with MULDIVREM_ARB_PERF_EN.
package muldivrem_share_arb_pkg;
  typedef enum logic [3:0] {
    UOP_MUL    = 4'd0,
    UOP_MULH   = 4'd1,
    UOP_MULHSU = 4'd2,
    UOP_MULHU  = 4'd3,
    UOP_DIV    = 4'd4,
    UOP_DIVU   = 4'd5,
    UOP_REM    = 4'd6,
    UOP_REMU   = 4'd7
  } rv_uop;
endpackage

module muldivrem_share_arb
  import muldivrem_share_arb_pkg::*;
#(
  parameter int p_seq_num_bits = 5,
  localparam int RQW = 101 + p_seq_num_bits + $bits(rv_uop),
  localparam int RSW = 70 + p_seq_num_bits
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_val,
  output logic           req0_rdy,
  input  logic [RQW-1:0] req0_msg,
  input  logic           req1_val,
  output logic           req1_rdy,
  input  logic [RQW-1:0] req1_msg,
  output logic           u_req_val,
  input  logic           u_req_rdy,
  output logic [RQW-1:0] u_req_msg,
  input  logic           u_resp_val,
  output logic           u_resp_rdy,
  input  logic [RSW-1:0] u_resp_msg,
  output logic           resp0_val,
  input  logic           resp0_rdy,
  output logic [RSW-1:0] resp0_msg,
  output logic           resp1_val,
  input  logic           resp1_rdy,
  output logic [RSW-1:0] resp1_msg
`ifdef MULDIVREM_ARB_PERF_EN
  ,
  output logic [31:0]    grant_cnt0,
  output logic [31:0]    grant_cnt1,
  output logic [31:0]    busy_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [1:0] req_val;
  logic       any_val;
  logic       winner;
  logic       issue_fire;
  logic       done_fire;

  assign req_val = {req1_val, req0_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs are forced low while rst is held so a mid-op reset silences both sides at once.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    any_val    = req0_val | req1_val;
    winner     = req_val[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
    issue_fire = 1'b0;
    done_fire  = 1'b0;
    u_req_val  = 1'b0;
    u_req_msg  = '0;
    req0_rdy   = 1'b0;
    req1_rdy   = 1'b0;
    u_resp_rdy = 1'b0;
    resp0_val  = 1'b0;
    resp1_val  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          u_req_val  = any_val;
          if (any_val) begin
            u_req_msg = winner ? req1_msg : req0_msg;
          end
          req0_rdy   = any_val && !winner && u_req_rdy;
          req1_rdy   = any_val && winner && u_req_rdy;
          issue_fire = any_val && u_req_rdy;
          if (issue_fire) begin
            state_d  = BUSY;
            owner_d  = winner;
            rr_ptr_d = ~winner;
          end
        end
        BUSY: begin
          resp0_val  = u_resp_val && !owner_q;
          resp1_val  = u_resp_val && owner_q;
          u_resp_rdy = owner_q ? resp1_rdy : resp0_rdy;
          done_fire  = u_resp_val && (owner_q ? resp1_rdy : resp0_rdy);
          if (done_fire) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign resp0_msg = u_resp_msg;
  assign resp1_msg = u_resp_msg;

`ifdef MULDIVREM_ARB_PERF_EN
  logic [31:0] grant_cnt0_q, grant_cnt1_q, busy_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0_q <= 32'd0;
      grant_cnt1_q <= 32'd0;
      busy_cnt_q   <= 32'd0;
    end else begin
      if (issue_fire && !winner) grant_cnt0_q <= grant_cnt0_q + 32'd1;
      if (issue_fire && winner)  grant_cnt1_q <= grant_cnt1_q + 32'd1;
      if (state_q == BUSY)       busy_cnt_q   <= busy_cnt_q + 32'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign busy_cnt   = busy_cnt_q;
`endif

`ifndef SYNTHESIS
  // A result with nothing in flight means the unit and arbiter disagree about ownership.
  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst)
    !(state_q == IDLE && u_resp_val));
`endif

endmodule
